tx_rx_axil_loopback_buffers: RTL and testbench

Two AXI4-Lite slave ports on one clock. The TX port writes 32-bit words into a TX input FIFO. A drain engine moves FIFO words into an 8-entry RX output buffer. Software reads that buffer over the RX port. The block is the software-visible data path around the VLC transmitter/receiver and also serves as a loopback for bring-up; buff_full reports TX FIFO back-pressure.

---
 rtl/tx_rx_axil_loopback_buffers_pkg.sv | 40 ++++
 rtl/tx_rx_axil_loopback_buffers_axil_slave_if.sv | 98 +++++++++
 rtl/tx_rx_axil_loopback_buffers.sv | 249 ++++++++++++++++++++++++
 tb/tb_tx_rx_axil_loopback_buffers.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_rx_axil_loopback_buffers_pkg.sv
// Shared register map, response codes and helpers for the TX/RX AXI-Lite loopback buffers.
// No logic of its own; imported by the top and the AXI-Lite slave front-end.
// Backpressure: n/a.
package tx_rx_axil_loopback_buffers_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int TX_ADDR_W  = 4;
  localparam int RX_ADDR_W  = 5;

  // TX register offsets, decoded from addr[3:2]
  typedef enum logic [1:0] {
    TX_REG_DATA    = 2'd0,
    TX_REG_STATUS  = 2'd1,
    TX_REG_CONTROL = 2'd2,
    TX_REG_RSVD    = 2'd3
  } tx_reg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // STATUS layout
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_CNT_LSB   = 8;
  localparam int STATUS_CNT_W     = 4;

  // Drain engine runs out of reset so the loopback works with no setup
  localparam logic DRAIN_EN_RST = 1'b1;

  // Zero every byte lane whose strobe is low
  function automatic logic [AXI_DATA_W-1:0] apply_wstrb(input logic [AXI_DATA_W-1:0] data,
                                                        input logic [AXI_DATA_W/8-1:0] strb);
    logic [AXI_DATA_W-1:0] masked;
    for (int b = 0; b < AXI_DATA_W / 8; b++) begin
      masked[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/tx_rx_axil_loopback_buffers_axil_slave_if.sv
// AXI4-Lite slave front-end: accepts one write and one read per cycle and registers the responses.
// Latency: aw/w/ar accepted combinationally; bvalid/rvalid rise the cycle after acceptance.
// Backpressure: a pending B (or R) response that is not taken stalls further writes (or reads).
module axil_slave_if
  import tx_rx_axil_loopback_buffers_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // AXI-Lite write address / data / response
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  // AXI-Lite read address / data
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rvalid,
  input  logic                i_rready,
  // Register-file side
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_strb,
  input  logic [1:0]          i_wr_resp,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [DATA_W-1:0]   i_rd_data,
  input  logic [1:0]          i_rd_resp
);

  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              w_wr_accept;
  logic              w_rd_accept;

  // A new transaction may only enter when its response slot is free or being drained this cycle
  assign w_wr_accept = i_awvalid && i_wvalid && (!r_bvalid || i_bready);
  assign w_rd_accept = i_arvalid && (!r_rvalid || i_rready);

  assign o_awready = w_wr_accept;
  assign o_wready  = w_wr_accept;
  assign o_arready = w_rd_accept;

  assign o_wr_en   = w_wr_accept;
  assign o_wr_addr = i_awaddr;
  assign o_wr_data = i_wdata;
  assign o_wr_strb = i_wstrb;
  assign o_rd_addr = i_araddr;

  assign o_bvalid = r_bvalid;
  assign o_bresp  = r_bresp;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_rresp  = r_rresp;

  // Write response slot: load on accept, hold until bready
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_accept) begin
      r_bvalid <= 1'b1;
      r_bresp  <= i_wr_resp;
    end else if (i_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data slot: capture register data on accept, hold until rready
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_rd_accept) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_rd_data;
      r_rresp  <= i_rd_resp;
    end else if (i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_rx_axil_loopback_buffers.sv
// TX AXI-Lite port pushes words into a FIFO; a drain engine copies them into an 8-entry RX ring read over the RX port.
// Latency: a pushed word is popped the next cycle (drain on) and readable by an RX read accepted one cycle after the pop.
// Backpressure: pushes into a full FIFO are dropped with SLVERR; buff_full mirrors the full state; AXI B/R stalls are per port.
module tx_rx_axil_loopback_buffers
  import tx_rx_axil_loopback_buffers_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int RX_WORDS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // TX port
  input  logic [3:0]           tx_axi_awaddr,
  input  logic [2:0]           tx_axi_awprot,
  input  logic                 tx_axi_awvalid,
  output logic                 tx_axi_awready,
  input  logic [DATA_W-1:0]    tx_axi_wdata,
  input  logic [DATA_W/8-1:0]  tx_axi_wstrb,
  input  logic                 tx_axi_wvalid,
  output logic                 tx_axi_wready,
  output logic [1:0]           tx_axi_bresp,
  output logic                 tx_axi_bvalid,
  input  logic                 tx_axi_bready,
  input  logic [3:0]           tx_axi_araddr,
  input  logic [2:0]           tx_axi_arprot,
  input  logic                 tx_axi_arvalid,
  output logic                 tx_axi_arready,
  output logic [DATA_W-1:0]    tx_axi_rdata,
  output logic [1:0]           tx_axi_rresp,
  output logic                 tx_axi_rvalid,
  input  logic                 tx_axi_rready,
  // RX port
  input  logic [4:0]           rx_axi_awaddr,
  input  logic [2:0]           rx_axi_awprot,
  input  logic                 rx_axi_awvalid,
  output logic                 rx_axi_awready,
  input  logic [DATA_W-1:0]    rx_axi_wdata,
  input  logic [DATA_W/8-1:0]  rx_axi_wstrb,
  input  logic                 rx_axi_wvalid,
  output logic                 rx_axi_wready,
  output logic [1:0]           rx_axi_bresp,
  output logic                 rx_axi_bvalid,
  input  logic                 rx_axi_bready,
  input  logic [4:0]           rx_axi_araddr,
  input  logic [2:0]           rx_axi_arprot,
  input  logic                 rx_axi_arvalid,
  output logic                 rx_axi_arready,
  output logic [DATA_W-1:0]    rx_axi_rdata,
  output logic [1:0]           rx_axi_rresp,
  output logic                 rx_axi_rvalid,
  input  logic                 rx_axi_rready,
  // TX FIFO back-pressure indication
  output logic                 buff_full
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int RX_PTR_W = $clog2(RX_WORDS);
  localparam int STRB_W   = DATA_W / 8;

  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [RX_PTR_W-1:0] RX_PTR_ONE = RX_PTR_W'(1);

  // TX slave register-side signals
  logic              w_tx_wr_en;
  logic [3:0]        w_tx_wr_addr;
  logic [DATA_W-1:0] w_tx_wr_data;
  logic [STRB_W-1:0] w_tx_wr_strb;
  logic [1:0]        w_tx_wr_resp;
  logic [3:0]        w_tx_rd_addr;
  logic [DATA_W-1:0] w_tx_rd_data;

  // RX slave register-side signals (RX writes have no effect)
  logic              w_rx_wr_en;
  logic [4:0]        w_rx_wr_addr;
  logic [DATA_W-1:0] w_rx_wr_data;
  logic [STRB_W-1:0] w_rx_wr_strb;
  logic [4:0]        w_rx_rd_addr;
  logic [DATA_W-1:0] w_rx_rd_data;

  // FIFO, drain engine and control state
  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_fifo_wr;
  logic [PTR_W-1:0]    r_fifo_rd;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [DATA_W-1:0]   r_rx_buf [RX_WORDS];
  logic [RX_PTR_W-1:0] r_rx_ptr;
  logic                r_drain_en;
  logic                r_buff_full;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_tx_wr_data_sel;
  logic                w_tx_wr_ctrl_sel;
  logic                w_unused;

  axil_slave_if #(.ADDR_W(TX_ADDR_W), .DATA_W(DATA_W)) u_tx_if (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_awaddr  (tx_axi_awaddr),
    .i_awvalid (tx_axi_awvalid),
    .o_awready (tx_axi_awready),
    .i_wdata   (tx_axi_wdata),
    .i_wstrb   (tx_axi_wstrb),
    .i_wvalid  (tx_axi_wvalid),
    .o_wready  (tx_axi_wready),
    .o_bresp   (tx_axi_bresp),
    .o_bvalid  (tx_axi_bvalid),
    .i_bready  (tx_axi_bready),
    .i_araddr  (tx_axi_araddr),
    .i_arvalid (tx_axi_arvalid),
    .o_arready (tx_axi_arready),
    .o_rdata   (tx_axi_rdata),
    .o_rresp   (tx_axi_rresp),
    .o_rvalid  (tx_axi_rvalid),
    .i_rready  (tx_axi_rready),
    .o_wr_en   (w_tx_wr_en),
    .o_wr_addr (w_tx_wr_addr),
    .o_wr_data (w_tx_wr_data),
    .o_wr_strb (w_tx_wr_strb),
    .i_wr_resp (w_tx_wr_resp),
    .o_rd_addr (w_tx_rd_addr),
    .i_rd_data (w_tx_rd_data),
    .i_rd_resp (RESP_OKAY)
  );

  axil_slave_if #(.ADDR_W(RX_ADDR_W), .DATA_W(DATA_W)) u_rx_if (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_awaddr  (rx_axi_awaddr),
    .i_awvalid (rx_axi_awvalid),
    .o_awready (rx_axi_awready),
    .i_wdata   (rx_axi_wdata),
    .i_wstrb   (rx_axi_wstrb),
    .i_wvalid  (rx_axi_wvalid),
    .o_wready  (rx_axi_wready),
    .o_bresp   (rx_axi_bresp),
    .o_bvalid  (rx_axi_bvalid),
    .i_bready  (rx_axi_bready),
    .i_araddr  (rx_axi_araddr),
    .i_arvalid (rx_axi_arvalid),
    .o_arready (rx_axi_arready),
    .o_rdata   (rx_axi_rdata),
    .o_rresp   (rx_axi_rresp),
    .o_rvalid  (rx_axi_rvalid),
    .i_rready  (rx_axi_rready),
    .o_wr_en   (w_rx_wr_en),
    .o_wr_addr (w_rx_wr_addr),
    .o_wr_data (w_rx_wr_data),
    .o_wr_strb (w_rx_wr_strb),
    .i_wr_resp (RESP_OKAY),
    .o_rd_addr (w_rx_rd_addr),
    .i_rd_data (w_rx_rd_data),
    .i_rd_resp (RESP_OKAY)
  );

  // Protection bits, byte offsets and the RX write channel carry no meaning here
  assign w_unused = ^{tx_axi_awprot, tx_axi_arprot, rx_axi_awprot, rx_axi_arprot,
                      w_tx_wr_addr[1:0], w_tx_rd_addr[1:0], w_rx_rd_addr[1:0],
                      w_rx_wr_en, w_rx_wr_addr, w_rx_wr_data, w_rx_wr_strb};

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  assign w_tx_wr_data_sel = (tx_reg_e'(w_tx_wr_addr[3:2]) == TX_REG_DATA);
  assign w_tx_wr_ctrl_sel = (tx_reg_e'(w_tx_wr_addr[3:2]) == TX_REG_CONTROL);

  // Full is judged on the current count, so a same-cycle pop never rescues a push into a full FIFO
  assign w_push       = w_tx_wr_en && w_tx_wr_data_sel && !w_full;
  assign w_pop        = r_drain_en && !w_empty;
  assign w_tx_wr_resp = (w_tx_wr_data_sel && w_full) ? RESP_SLVERR : RESP_OKAY;

  assign buff_full    = r_buff_full;
  assign w_rx_rd_data = r_rx_buf[w_rx_rd_addr[4:2]];

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // FIFO storage needs no reset: the count guards every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_fifo_wr] <= apply_wstrb(w_tx_wr_data, w_tx_wr_strb);
    end
  end

  // FIFO pointers, count and the registered full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo_wr   <= '0;
      r_fifo_rd   <= '0;
      r_count     <= '0;
      r_buff_full <= 1'b0;
    end else begin
      if (w_push) r_fifo_wr <= r_fifo_wr + PTR_ONE;
      if (w_pop)  r_fifo_rd <= r_fifo_rd + PTR_ONE;
      r_count     <= w_count_nxt;
      r_buff_full <= (w_count_nxt == CNT_FULL);
    end
  end

  // Drain engine: one word per cycle into the RX ring, oldest entry overwritten on wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_WORDS; i++) begin
        r_rx_buf[i] <= '0;
      end
      r_rx_ptr <= '0;
    end else if (w_pop) begin
      r_rx_buf[r_rx_ptr] <= r_fifo[r_fifo_rd];
      r_rx_ptr           <= r_rx_ptr + RX_PTR_ONE;
    end
  end

  // CONTROL register: only byte lane 0 carries DRAIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_en <= DRAIN_EN_RST;
    end else if (w_tx_wr_en && w_tx_wr_ctrl_sel && w_tx_wr_strb[0]) begin
      r_drain_en <= w_tx_wr_data[0];
    end
  end

  // TX read mux; DATA and the reserved slot read as zero
  always_comb begin
    w_tx_rd_data = '0;
    case (tx_reg_e'(w_tx_rd_addr[3:2]))
      TX_REG_STATUS: begin
        w_tx_rd_data[STATUS_FULL_BIT]                 = w_full;
        w_tx_rd_data[STATUS_EMPTY_BIT]                = w_empty;
        w_tx_rd_data[STATUS_CNT_LSB +: STATUS_CNT_W]  = STATUS_CNT_W'(r_count);
      end
      TX_REG_CONTROL: w_tx_rd_data[0] = r_drain_en;
      default: w_tx_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_tx_rx_axil_loopback_buffers.sv
// Randomised and directed bench for the TX/RX AXI-Lite loopback buffers against a queue-based model.
// Transactions are driven #1 after the rising edge and sampled on the falling edge.
// Every wait on the DUT is bounded; a timeout is reported as a failed check.
module tb_tx_rx_axil_loopback_buffers;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  tx_axi_awaddr, tx_axi_araddr;
  logic [2:0]  tx_axi_awprot, tx_axi_arprot;
  logic        tx_axi_awvalid, tx_axi_awready, tx_axi_wvalid, tx_axi_wready;
  logic [31:0] tx_axi_wdata, tx_axi_rdata;
  logic [3:0]  tx_axi_wstrb;
  logic [1:0]  tx_axi_bresp, tx_axi_rresp;
  logic        tx_axi_bvalid, tx_axi_bready, tx_axi_arvalid, tx_axi_arready, tx_axi_rvalid, tx_axi_rready;
  logic [4:0]  rx_axi_awaddr, rx_axi_araddr;
  logic [2:0]  rx_axi_awprot, rx_axi_arprot;
  logic        rx_axi_awvalid, rx_axi_awready, rx_axi_wvalid, rx_axi_wready;
  logic [31:0] rx_axi_wdata, rx_axi_rdata;
  logic [3:0]  rx_axi_wstrb;
  logic [1:0]  rx_axi_bresp, rx_axi_rresp;
  logic        rx_axi_bvalid, rx_axi_bready, rx_axi_arvalid, rx_axi_arready, rx_axi_rvalid, rx_axi_rready;
  logic        buff_full;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: FIFO as a queue, RX ring as an array
  logic [31:0] m_fifo[$];
  logic [31:0] m_rx[8];
  int          m_ptr;
  bit          m_drain;

  always #5 clk = ~clk;

  tx_rx_axil_loopback_buffers dut (
    .clk(clk), .reset(reset),
    .tx_axi_awaddr(tx_axi_awaddr), .tx_axi_awprot(tx_axi_awprot), .tx_axi_awvalid(tx_axi_awvalid),
    .tx_axi_awready(tx_axi_awready), .tx_axi_wdata(tx_axi_wdata), .tx_axi_wstrb(tx_axi_wstrb),
    .tx_axi_wvalid(tx_axi_wvalid), .tx_axi_wready(tx_axi_wready), .tx_axi_bresp(tx_axi_bresp),
    .tx_axi_bvalid(tx_axi_bvalid), .tx_axi_bready(tx_axi_bready), .tx_axi_araddr(tx_axi_araddr),
    .tx_axi_arprot(tx_axi_arprot), .tx_axi_arvalid(tx_axi_arvalid), .tx_axi_arready(tx_axi_arready),
    .tx_axi_rdata(tx_axi_rdata), .tx_axi_rresp(tx_axi_rresp), .tx_axi_rvalid(tx_axi_rvalid),
    .tx_axi_rready(tx_axi_rready),
    .rx_axi_awaddr(rx_axi_awaddr), .rx_axi_awprot(rx_axi_awprot), .rx_axi_awvalid(rx_axi_awvalid),
    .rx_axi_awready(rx_axi_awready), .rx_axi_wdata(rx_axi_wdata), .rx_axi_wstrb(rx_axi_wstrb),
    .rx_axi_wvalid(rx_axi_wvalid), .rx_axi_wready(rx_axi_wready), .rx_axi_bresp(rx_axi_bresp),
    .rx_axi_bvalid(rx_axi_bvalid), .rx_axi_bready(rx_axi_bready), .rx_axi_araddr(rx_axi_araddr),
    .rx_axi_arprot(rx_axi_arprot), .rx_axi_arvalid(rx_axi_arvalid), .rx_axi_arready(rx_axi_arready),
    .rx_axi_rdata(rx_axi_rdata), .rx_axi_rresp(rx_axi_rresp), .rx_axi_rvalid(rx_axi_rvalid),
    .rx_axi_rready(rx_axi_rready),
    .buff_full(buff_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic void m_reset();
    m_fifo.delete();
    for (int i = 0; i < 8; i++) m_rx[i] = '0;
    m_ptr   = 0;
    m_drain = 1'b1;
  endfunction

  function automatic void m_drain_all();
    while (m_drain && m_fifo.size() > 0) begin
      m_rx[m_ptr] = m_fifo.pop_front();
      m_ptr = (m_ptr + 1) % 8;
    end
  endfunction

  function automatic logic [1:0] m_push(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
    if (m_fifo.size() == DEPTH) return 2'b10;
    m_fifo.push_back(v);
    m_drain_all();
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v     = '0;
    v[0]  = (m_fifo.size() == DEPTH);
    v[1]  = (m_fifo.size() == 0);
    v[11:8] = 4'(m_fifo.size());
    return v;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic axi_write(input bit rx, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic full_b);
    int n;
    @(posedge clk); #1;
    if (rx) begin
      rx_axi_awaddr = addr; rx_axi_wdata = d; rx_axi_wstrb = s; rx_axi_awvalid = 1'b1; rx_axi_wvalid = 1'b1;
    end else begin
      tx_axi_awaddr = addr[3:0]; tx_axi_wdata = d; tx_axi_wstrb = s; tx_axi_awvalid = 1'b1; tx_axi_wvalid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(rx ? rx_axi_awready : tx_axi_awready) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("awready_seen", 32'(n < TMO), 32'd1);
    @(posedge clk); #1;
    rx_axi_awvalid = 1'b0; rx_axi_wvalid = 1'b0; tx_axi_awvalid = 1'b0; tx_axi_wvalid = 1'b0;
    @(negedge clk);
    chk("bvalid_next_cycle", 32'(rx ? rx_axi_bvalid : tx_axi_bvalid), 32'd1);
    resp   = rx ? rx_axi_bresp : tx_axi_bresp;
    full_b = buff_full;
  endtask

  task automatic axi_read(input bit rx, input logic [4:0] addr, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    if (rx) begin rx_axi_araddr = addr; rx_axi_arvalid = 1'b1; end
    else begin tx_axi_araddr = addr[3:0]; tx_axi_arvalid = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(rx ? rx_axi_arready : tx_axi_arready) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("arready_seen", 32'(n < TMO), 32'd1);
    @(posedge clk); #1;
    rx_axi_arvalid = 1'b0; tx_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_next_cycle", 32'(rx ? rx_axi_rvalid : tx_axi_rvalid), 32'd1);
    d    = rx ? rx_axi_rdata : tx_axi_rdata;
    resp = rx ? rx_axi_rresp : tx_axi_rresp;
  endtask

  task automatic tx_push(input string tag, input logic [31:0] d, input logic [3:0] s, output logic full_b);
    logic [1:0] r, e;
    axi_write(1'b0, 5'h00, d, s, r, full_b);
    e = m_push(d, s);
    chk(tag, 32'(r), 32'(e));
  endtask

  task automatic tx_ctrl(input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    logic       fb;
    axi_write(1'b0, 5'h08, d, s, r, fb);
    chk("ctrl_bresp", 32'(r), 32'd0);
    if (s[0]) m_drain = d[0];
    m_drain_all();
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(1'b0, {3'b001, 2'($urandom_range(0, 3))}, d, r);
    chk(tag, d, m_status());
    chk("status_full_pin", 32'(buff_full), 32'(m_fifo.size() == DEPTH));
  endtask

  task automatic check_rx(input string tag, input int slot);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(1'b1, {3'(slot), 2'($urandom_range(0, 3))}, d, r);
    chk(tag, d, m_rx[slot]);
    chk("rx_rresp", 32'(r), 32'd0);
  endtask

  task automatic check_rx_all(input string tag, input int nslots);
    for (int s = 0; s < nslots; s++) check_rx(tag, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    settle(2);
    #1 reset = 1'b0;
    m_reset();
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        fb, fb7;
    int          n;
    bit          stall_seen, hold_ok;

    tx_axi_awaddr = '0; tx_axi_awprot = '0; tx_axi_awvalid = 0; tx_axi_wdata = '0; tx_axi_wstrb = '0;
    tx_axi_wvalid = 0; tx_axi_bready = 1; tx_axi_araddr = '0; tx_axi_arprot = '0; tx_axi_arvalid = 0;
    tx_axi_rready = 1;
    rx_axi_awaddr = '0; rx_axi_awprot = '0; rx_axi_awvalid = 0; rx_axi_wdata = '0; rx_axi_wstrb = '0;
    rx_axi_wvalid = 0; rx_axi_bready = 1; rx_axi_araddr = '0; rx_axi_arprot = '0; rx_axi_arvalid = 0;
    rx_axi_rready = 1;
    reset = 1'b1;
    m_reset();

    // Reset state
    @(negedge clk);
    chk("rst_tx_hs", 32'({tx_axi_awready, tx_axi_wready, tx_axi_bvalid, tx_axi_arready, tx_axi_rvalid}), 32'd0);
    chk("rst_rx_hs", 32'({rx_axi_awready, rx_axi_wready, rx_axi_bvalid, rx_axi_arready, rx_axi_rvalid}), 32'd0);
    chk("rst_resp", 32'({tx_axi_bresp, tx_axi_rresp, rx_axi_bresp, rx_axi_rresp}), 32'd0);
    chk("rst_rdata", tx_axi_rdata | rx_axi_rdata, 32'd0);
    chk("rst_buff_full", 32'(buff_full), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    check_status("rst_status");
    axi_read(1'b0, 5'h08, d, r);
    chk("rst_drain_en", d, 32'd1);
    check_rx_all("rst_rx", 8);

    // Alternating 0 / all-ones loopback
    for (int i = 0; i < 7; i++) tx_push("t1_bresp", (i % 2) ? 32'hFFFF_FFFF : 32'h0, 4'hF, fb);
    chk("t1_buff_full", 32'(fb), 32'd0);
    settle(3);
    check_rx_all("t1_rx", 7);

    // Fill with drain off, overflow, then drain
    do_reset();
    tx_ctrl(32'd0, 4'h1);
    fb7 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_push("t2_bresp", 32'h100 + 32'(i), 4'hF, fb);
      if (i == 6) fb7 = fb;
    end
    chk("t2_full_after_7th", 32'(fb7), 32'd0);
    chk("t2_full_after_8th", 32'(fb), 32'd1);
    tx_push("t2_overflow_bresp", 32'hDEAD_BEEF, 4'hF, fb);
    check_status("t2_status_full");
    tx_ctrl(32'd1, 4'h1);
    settle(10);
    chk("t2_drained_full_pin", 32'(buff_full), 32'd0);
    check_status("t2_status_empty");
    check_rx_all("t2_rx", 8);

    // Wrap-around of the RX ring
    do_reset();
    for (int i = 1; i <= 10; i++) tx_push("t3_bresp", 32'(i), 4'hF, fb);
    settle(3);
    check_rx_all("t3_rx", 8);

    // B-channel back-pressure
    tx_axi_bready = 1'b0;
    @(posedge clk); #1;
    tx_axi_awaddr = 4'h0; tx_axi_wdata = 32'h1111_0001; tx_axi_wstrb = 4'hF;
    tx_axi_awvalid = 1'b1; tx_axi_wvalid = 1'b1;
    @(negedge clk);
    chk("t4_first_accept", 32'(tx_axi_awready), 32'd1);
    @(posedge clk); #1;
    void'(m_push(32'h1111_0001, 4'hF));
    tx_axi_wdata = 32'h2222_0002;
    stall_seen = 1'b0; hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stall_seen |= tx_axi_awready;
      hold_ok    &= tx_axi_bvalid;
    end
    chk("t4_second_stalled", 32'(stall_seen), 32'd0);
    chk("t4_bvalid_held", 32'(hold_ok), 32'd1);
    @(posedge clk); #1 tx_axi_bready = 1'b1;
    @(negedge clk);
    chk("t4_second_accept", 32'(tx_axi_awready), 32'd1);
    @(posedge clk); #1;
    tx_axi_awvalid = 1'b0; tx_axi_wvalid = 1'b0;
    void'(m_push(32'h2222_0002, 4'hF));
    @(negedge clk);
    chk("t4_second_bvalid", 32'(tx_axi_bvalid), 32'd1);
    chk("t4_second_bresp", 32'(tx_axi_bresp), 32'd0);
    settle(3);
    check_rx_all("t4_rx", 8);

    // Partial strobes
    do_reset();
    tx_push("t5_bresp", 32'hAABB_CCDD, 4'b0011, fb);
    settle(3);
    check_rx("t5_rx_strb", 0);
    chk("t5_model_strb", m_rx[0], 32'h0000_CCDD);

    // Reset with a pending response and a partly filled FIFO
    do_reset();
    tx_ctrl(32'd0, 4'h1);
    for (int i = 0; i < 3; i++) tx_push("t6_bresp", $urandom, 4'hF, fb);
    check_status("t6_status_3");
    tx_axi_bready = 1'b0;
    @(posedge clk); #1;
    tx_axi_awaddr = 4'hC; tx_axi_wstrb = 4'hF; tx_axi_awvalid = 1'b1; tx_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_axi_awready && n < TMO) begin @(negedge clk); n++; end
    chk("t6_accept_seen", 32'(n < TMO), 32'd1);
    @(posedge clk); #1;
    tx_axi_awvalid = 1'b0; tx_axi_wvalid = 1'b0;
    @(negedge clk);
    chk("t6_bvalid_pending", 32'(tx_axi_bvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_bvalid_async_clear", 32'(tx_axi_bvalid), 32'd0);
    settle(2);
    #1 reset = 1'b0;
    tx_axi_bready = 1'b1;
    m_reset();
    check_status("t6_status_after_reset");
    check_rx_all("t6_rx_zero", 8);

    // Randomised traffic against the model
    for (int k = 0; k < 160; k++) begin
      int          op;
      logic [31:0] rd;
      logic [3:0]  rs;
      op = $urandom_range(0, 9);
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      if (op <= 4) begin
        tx_push("rnd_push_bresp", rd, rs, fb);
      end else if (op == 5) begin
        tx_ctrl(rd, rs);
        settle(12);
      end else if (op == 6) begin
        check_status("rnd_status");
      end else if (op == 7) begin
        check_rx("rnd_rx", $urandom_range(0, 7));
      end else if (op == 8) begin
        if (rd[0]) axi_write(1'b1, 5'($urandom_range(0, 31)), rd, rs, r, fb);
        else       axi_write(1'b0, {3'b011, 2'($urandom_range(0, 3))}, rd, rs, r, fb);
        chk("rnd_ignored_write_bresp", 32'(r), 32'd0);
      end else begin
        n = $urandom_range(0, 3);
        axi_read(1'b0, {1'b0, 2'(n), 2'($urandom_range(0, 3))}, d, r);
        chk("rnd_tx_read", d, (n == 1) ? m_status() : (n == 2) ? 32'(m_drain) : 32'd0);
        chk("rnd_tx_rresp", 32'(r), 32'd0);
      end
    end
    settle(12);
    check_rx_all("final_rx", 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
